// File: rtl/mem_bus_arbiter_if.sv
// Bundle of requester-side and memory-side signals for mem_bus_arbiter.
// slave = arbiter view, master = requester/memory environment view.
interface mem_bus_arbiter_if #(
    parameter int AW = 13,
    parameter int DW = 8
);
    logic          req0;
    logic          req1;
    logic [AW-1:0] addr0;
    logic [AW-1:0] addr1;
    logic          rd0;
    logic          wr0;
    logic          rd1;
    logic          wr1;
    logic [DW-1:0] wdata0;
    logic [DW-1:0] wdata1;
    logic          gnt0;
    logic          gnt1;
    logic [AW-1:0] mem_addr;
    logic          mem_rd;
    logic          mem_wr;
    logic [DW-1:0] mem_wdata;
    logic          busy;
    logic          timeout_err;

    modport slave (
        input  req0, req1, addr0, addr1, rd0, wr0, rd1, wr1, wdata0, wdata1,
        output gnt0, gnt1, mem_addr, mem_rd, mem_wr, mem_wdata, busy, timeout_err
    );

    modport master (
        output req0, req1, addr0, addr1, rd0, wr0, rd1, wr1, wdata0, wdata1,
        input  gnt0, gnt1, mem_addr, mem_rd, mem_wr, mem_wdata, busy, timeout_err
    );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Two-requester round-robin memory bus arbiter with one turnaround cycle between owners.
// Define MEM_ARB_TIMEOUT_EN to force release of an owner held for TIMEOUT cycles while the other waits.
module mem_bus_arbiter #(
    parameter int AW      = 13,
    parameter int DW      = 8,
    parameter int TIMEOUT = 64
) (
    input  logic                clk,
    input  logic                rst,
    mem_bus_arbiter_if.slave    bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2,
        TURN = 2'd3
    } state_t;

    state_t        state_r;
    state_t        state_s;
    logic          last_winner_r;
    logic          last_winner_s;
    logic          timeout_s;
    logic          tmo_hit_s;
    logic          gnt0_r;
    logic          gnt1_r;
    logic          busy_r;
    logic          timeout_err_r;
    logic [AW-1:0] addr_hold_r;
    logic [DW-1:0] wdata_hold_r;
    logic [AW-1:0] mem_addr_s;
    logic [DW-1:0] mem_wdata_s;
    logic          mem_rd_s;
    logic          mem_wr_s;

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] own_cnt_r;
    logic          own_entry_s;

    assign own_entry_s = ((state_s == OWN0) && (state_r != OWN0)) ||
                         ((state_s == OWN1) && (state_r != OWN1));

    // Owned-cycle counter: cleared on entry, saturates at TIMEOUT
    always_ff @(posedge clk) begin
        if (rst) begin
            own_cnt_r <= {CW{1'b0}};
        end else if (own_entry_s) begin
            own_cnt_r <= {CW{1'b0}};
        end else if (((state_r == OWN0) || (state_r == OWN1)) && (own_cnt_r != CW'(TIMEOUT))) begin
            own_cnt_r <= own_cnt_r + CW'(1);
        end else begin
            own_cnt_r <= own_cnt_r;
        end
    end

    // The current cycle is the TIMEOUT-th owned cycle (or later, once saturated)
    assign tmo_hit_s = (own_cnt_r >= CW'(TIMEOUT - 1));
`else
    assign tmo_hit_s = 1'b0;
`endif

    // Next-state, round-robin winner and forced-release decision
    always_comb begin
        state_s       = state_r;
        last_winner_s = last_winner_r;
        timeout_s     = 1'b0;
        case (state_r)
            IDLE: begin
                if (bus.req0 && bus.req1) begin
                    if (last_winner_r) begin
                        state_s       = OWN0;
                        last_winner_s = 1'b0;
                    end else begin
                        state_s       = OWN1;
                        last_winner_s = 1'b1;
                    end
                end else if (bus.req0) begin
                    state_s       = OWN0;
                    last_winner_s = 1'b0;
                end else if (bus.req1) begin
                    state_s       = OWN1;
                    last_winner_s = 1'b1;
                end else begin
                    state_s = IDLE;
                end
            end
            OWN0: begin
                if (!bus.req0) begin
                    state_s = TURN;
                end else if (tmo_hit_s && bus.req1) begin
                    state_s       = TURN;
                    timeout_s     = 1'b1;
                    last_winner_s = 1'b0;
                end else begin
                    state_s = OWN0;
                end
            end
            OWN1: begin
                if (!bus.req1) begin
                    state_s = TURN;
                end else if (tmo_hit_s && bus.req0) begin
                    state_s       = TURN;
                    timeout_s     = 1'b1;
                    last_winner_s = 1'b1;
                end else begin
                    state_s = OWN1;
                end
            end
            TURN: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State register and round-robin pointer (requester 0 wins the first tie)
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= IDLE;
            last_winner_r <= 1'b1;
        end else begin
            state_r       <= state_s;
            last_winner_r <= last_winner_s;
        end
    end

    // Grant/busy/timeout flags registered from the next state so they align with it
    always_ff @(posedge clk) begin
        if (rst) begin
            gnt0_r        <= 1'b0;
            gnt1_r        <= 1'b0;
            busy_r        <= 1'b0;
            timeout_err_r <= 1'b0;
        end else begin
            gnt0_r        <= (state_s == OWN0);
            gnt1_r        <= (state_s == OWN1);
            busy_r        <= (state_s == OWN0) || (state_s == OWN1);
            timeout_err_r <= timeout_s;
        end
    end

    // Last owner-driven address/data, replayed on the port while nobody owns it
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_hold_r  <= {AW{1'b0}};
            wdata_hold_r <= {DW{1'b0}};
        end else if (state_r == OWN0) begin
            addr_hold_r  <= bus.addr0;
            wdata_hold_r <= bus.wdata0;
        end else if (state_r == OWN1) begin
            addr_hold_r  <= bus.addr1;
            wdata_hold_r <= bus.wdata1;
        end else begin
            addr_hold_r  <= addr_hold_r;
            wdata_hold_r <= wdata_hold_r;
        end
    end

    // Memory port mux; only the owner's strobes can ever reach the port
    always_comb begin
        mem_addr_s  = addr_hold_r;
        mem_wdata_s = wdata_hold_r;
        mem_rd_s    = 1'b0;
        mem_wr_s    = 1'b0;
        case (state_r)
            OWN0: begin
                mem_addr_s  = bus.addr0;
                mem_wdata_s = bus.wdata0;
                mem_rd_s    = bus.rd0;
                mem_wr_s    = bus.wr0;
            end
            OWN1: begin
                mem_addr_s  = bus.addr1;
                mem_wdata_s = bus.wdata1;
                mem_rd_s    = bus.rd1;
                mem_wr_s    = bus.wr1;
            end
            default: begin
                mem_rd_s = 1'b0;
                mem_wr_s = 1'b0;
            end
        endcase
    end

    assign bus.gnt0        = gnt0_r;
    assign bus.gnt1        = gnt1_r;
    assign bus.busy        = busy_r;
    assign bus.timeout_err = timeout_err_r;
    assign bus.mem_addr    = mem_addr_s;
    assign bus.mem_wdata   = mem_wdata_s;
    assign bus.mem_rd      = mem_rd_s;
    assign bus.mem_wr      = mem_wr_s;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed scoreboard bench for mem_bus_arbiter: expected port values are queued per cycle
// and compared one cycle later; define MEM_ARB_TIMEOUT_EN to exercise forced release (TIMEOUT=8).
module tb_mem_bus_arbiter;

    typedef struct {
        string       tag;
        logic        g0;
        logic        g1;
        logic        rd;
        logic        wr;
        logic [12:0] addr;
        logic [7:0]  wdata;
        logic        terr;
    } exp_t;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    exp_t sb_q[$];

    mem_bus_arbiter_if #(.AW(13), .DW(8)) bus_if ();

    mem_bus_arbiter #(.AW(13), .DW(8), .TIMEOUT(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cmp(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    // Queue the expectation for the next edge, advance, then pop and compare
    task automatic tick(input string tag, input logic g0, input logic g1, input logic rd,
                        input logic wr, input logic [12:0] addr, input logic [7:0] wd,
                        input logic terr);
        exp_t e;
        e.tag = tag; e.g0 = g0; e.g1 = g1; e.rd = rd; e.wr = wr;
        e.addr = addr; e.wdata = wd; e.terr = terr;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            cmp({tag, "_sb_empty"}, 32'd0, 32'd1);
        end else begin
            e = sb_q.pop_front();
            cmp({e.tag, "_gnt0"}, {31'd0, bus_if.gnt0}, {31'd0, e.g0});
            cmp({e.tag, "_gnt1"}, {31'd0, bus_if.gnt1}, {31'd0, e.g1});
            cmp({e.tag, "_busy"}, {31'd0, bus_if.busy}, {31'd0, e.g0 | e.g1});
            cmp({e.tag, "_excl"}, {31'd0, bus_if.gnt0 & bus_if.gnt1}, 32'd0);
            cmp({e.tag, "_rd"}, {31'd0, bus_if.mem_rd}, {31'd0, e.rd});
            cmp({e.tag, "_wr"}, {31'd0, bus_if.mem_wr}, {31'd0, e.wr});
            cmp({e.tag, "_addr"}, {19'd0, bus_if.mem_addr}, {19'd0, e.addr});
            cmp({e.tag, "_wdata"}, {24'd0, bus_if.mem_wdata}, {24'd0, e.wdata});
            cmp({e.tag, "_terr"}, {31'd0, bus_if.timeout_err}, {31'd0, e.terr});
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [12:0] a0;
        logic [12:0] a1;
        logic        own;
        checks = 0;
        errors = 0;
        rst = 1'b1;
        bus_if.req0 = 1'b0;   bus_if.req1 = 1'b0;
        bus_if.addr0 = 13'h0; bus_if.addr1 = 13'h0;
        bus_if.rd0 = 1'b0;    bus_if.wr0 = 1'b0;
        bus_if.rd1 = 1'b0;    bus_if.wr1 = 1'b0;
        bus_if.wdata0 = 8'h0; bus_if.wdata1 = 8'h0;

        // Reset state
        tick("rst_a", 1'b0, 1'b0, 1'b0, 1'b0, 13'h0, 8'h0, 1'b0);
        tick("rst_b", 1'b0, 1'b0, 1'b0, 1'b0, 13'h0, 8'h0, 1'b0);
        rst = 1'b0;
        tick("idle", 1'b0, 1'b0, 1'b0, 1'b0, 13'h0, 8'h0, 1'b0);

        // Single requester 0 read, one-cycle grant latency
        bus_if.req0 = 1'b1; bus_if.addr0 = 13'h0A5;
        tick("t1_gnt", 1'b1, 1'b0, 1'b0, 1'b0, 13'h0A5, 8'h0, 1'b0);
        bus_if.rd0 = 1'b1;
        tick("t1_rd", 1'b1, 1'b0, 1'b1, 1'b0, 13'h0A5, 8'h0, 1'b0);
        bus_if.rd0 = 1'b0; bus_if.req0 = 1'b0;
        tick("t1_turn", 1'b0, 1'b0, 1'b0, 1'b0, 13'h0A5, 8'h0, 1'b0);
        tick("t1_idle", 1'b0, 1'b0, 1'b0, 1'b0, 13'h0A5, 8'h0, 1'b0);

        // Simultaneous requests after reset: requester 0 first, then 1 after turnaround
        rst = 1'b1;
        tick("t2_rst", 1'b0, 1'b0, 1'b0, 1'b0, 13'h0, 8'h0, 1'b0);
        rst = 1'b0;
        bus_if.req0 = 1'b1; bus_if.addr0 = 13'h011; bus_if.wdata0 = 8'h55;
        bus_if.req1 = 1'b1; bus_if.addr1 = 13'h122; bus_if.wdata1 = 8'h3C; bus_if.wr1 = 1'b1;
        tick("t2_g0a", 1'b1, 1'b0, 1'b0, 1'b0, 13'h011, 8'h55, 1'b0);
        tick("t2_g0b", 1'b1, 1'b0, 1'b0, 1'b0, 13'h011, 8'h55, 1'b0);
        bus_if.req0 = 1'b0;
        tick("t2_turn", 1'b0, 1'b0, 1'b0, 1'b0, 13'h011, 8'h55, 1'b0);
        tick("t2_idle", 1'b0, 1'b0, 1'b0, 1'b0, 13'h011, 8'h55, 1'b0);
        tick("t2_g1", 1'b0, 1'b1, 1'b0, 1'b1, 13'h122, 8'h3C, 1'b0);
        bus_if.wr1 = 1'b0;
        tick("t2_own1", 1'b0, 1'b1, 1'b0, 1'b0, 13'h122, 8'h3C, 1'b0);
        bus_if.req1 = 1'b0;
        tick("t2_turn1", 1'b0, 1'b0, 1'b0, 1'b0, 13'h122, 8'h3C, 1'b0);
        tick("t2_idle1", 1'b0, 1'b0, 1'b0, 1'b0, 13'h122, 8'h3C, 1'b0);

        // Both held, each owner releases after 4 cycles: expect 0,1,0,1
        a0 = 13'h100; a1 = 13'h200;
        bus_if.addr0 = a0; bus_if.addr1 = a1;
        bus_if.req0 = 1'b1; bus_if.req1 = 1'b1;
        for (int k = 0; k < 4; k++) begin
            own = k[0];
            for (int c = 0; c < 4; c++) begin
                tick($sformatf("t3_own%0d_c%0d", k, c), ~own, own, 1'b0, 1'b0,
                     own ? a1 : a0, own ? 8'h3C : 8'h55, 1'b0);
            end
            if (own) bus_if.req1 = 1'b0; else bus_if.req0 = 1'b0;
            tick($sformatf("t3_turn%0d", k), 1'b0, 1'b0, 1'b0, 1'b0,
                 own ? a1 : a0, own ? 8'h3C : 8'h55, 1'b0);
            if (k < 3) begin
                if (own) bus_if.req1 = 1'b1; else bus_if.req0 = 1'b1;
            end else begin
                bus_if.req0 = 1'b0; bus_if.req1 = 1'b0;
            end
            tick($sformatf("t3_idle%0d", k), 1'b0, 1'b0, 1'b0, 1'b0,
                 own ? a1 : a0, own ? 8'h3C : 8'h55, 1'b0);
        end

        // Non-owner strobes must not reach the port
        bus_if.req0 = 1'b1; bus_if.addr0 = 13'h0C3; bus_if.wdata0 = 8'h11;
        tick("t4_gnt", 1'b1, 1'b0, 1'b0, 1'b0, 13'h0C3, 8'h11, 1'b0);
        bus_if.wr1 = 1'b1; bus_if.rd1 = 1'b1; bus_if.addr1 = 13'h1FF;
        tick("t4_foreign", 1'b1, 1'b0, 1'b0, 1'b0, 13'h0C3, 8'h11, 1'b0);
        bus_if.wr0 = 1'b1; bus_if.wdata0 = 8'hA7;
        tick("t4_ownwr", 1'b1, 1'b0, 1'b0, 1'b1, 13'h0C3, 8'hA7, 1'b0);
        bus_if.wr0 = 1'b0; bus_if.wr1 = 1'b0; bus_if.rd1 = 1'b0; bus_if.req0 = 1'b0;
        tick("t4_turn", 1'b0, 1'b0, 1'b0, 1'b0, 13'h0C3, 8'hA7, 1'b0);
        tick("t4_idle", 1'b0, 1'b0, 1'b0, 1'b0, 13'h0C3, 8'hA7, 1'b0);

        // Reset during an OWN1 write
        bus_if.req1 = 1'b1; bus_if.wr1 = 1'b1; bus_if.addr1 = 13'h0F0; bus_if.wdata1 = 8'h3C;
        tick("t5_g1", 1'b0, 1'b1, 1'b0, 1'b1, 13'h0F0, 8'h3C, 1'b0);
        rst = 1'b1;
        tick("t5_rst", 1'b0, 1'b0, 1'b0, 1'b0, 13'h0, 8'h0, 1'b0);
        rst = 1'b0;
        bus_if.req0 = 1'b1; bus_if.addr0 = 13'h077; bus_if.wdata0 = 8'h22;
        tick("t5_g0", 1'b1, 1'b0, 1'b0, 1'b0, 13'h077, 8'h22, 1'b0);
        bus_if.req0 = 1'b0; bus_if.req1 = 1'b0; bus_if.wr1 = 1'b0;
        tick("t5_turn", 1'b0, 1'b0, 1'b0, 1'b0, 13'h077, 8'h22, 1'b0);
        tick("t5_idle", 1'b0, 1'b0, 1'b0, 1'b0, 13'h077, 8'h22, 1'b0);

        // Long ownership with requester 1 waiting
        bus_if.req0 = 1'b1; bus_if.addr0 = 13'h055; bus_if.addr1 = 13'h0AA;
        tick("t6_g0", 1'b1, 1'b0, 1'b0, 1'b0, 13'h055, 8'h22, 1'b0);
        bus_if.req1 = 1'b1;
`ifdef MEM_ARB_TIMEOUT_EN
        for (int c = 0; c < 7; c++) begin
            tick($sformatf("t6_hold%0d", c), 1'b1, 1'b0, 1'b0, 1'b0, 13'h055, 8'h22, 1'b0);
        end
        tick("t6_force", 1'b0, 1'b0, 1'b0, 1'b0, 13'h055, 8'h22, 1'b1);
        tick("t6_idle", 1'b0, 1'b0, 1'b0, 1'b0, 13'h055, 8'h22, 1'b0);
        tick("t6_g1", 1'b0, 1'b1, 1'b0, 1'b0, 13'h0AA, 8'h3C, 1'b0);
        bus_if.req0 = 1'b0; bus_if.req1 = 1'b0;
        tick("t6_turn", 1'b0, 1'b0, 1'b0, 1'b0, 13'h0AA, 8'h3C, 1'b0);
`else
        for (int c = 0; c < 20; c++) begin
            tick($sformatf("t6_hold%0d", c), 1'b1, 1'b0, 1'b0, 1'b0, 13'h055, 8'h22, 1'b0);
        end
        bus_if.req0 = 1'b0; bus_if.req1 = 1'b0;
        tick("t6_turn", 1'b0, 1'b0, 1'b0, 1'b0, 13'h055, 8'h22, 1'b0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
